// File: rtl/regfile_mp_if.sv
// Register file access bus: decode-side read addresses, writeback port and clear control.
// The master is the datapath; the slave is regfile_mp.
interface regfile_mp_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     init_req;
    logic                     busy;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, init_req,
        input  rd_data, busy
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, init_req,
        output rd_data, busy
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file with hardwired-zero entry 0 and a clear sequencer.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_mp #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_RD = 2
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);
    localparam int unsigned DEPTH = 2**ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    state_e                   state_q, state_d;
    logic [ADDR_W-1:0]        clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0]        mem_q [DEPTH];
    logic                     busy_c;
    logic                     clr_we_c;
    logic                     wr_fire_c;
    logic [NUM_RD*DATA_W-1:0] rd_data_c;

    // Sequencer state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Next state: sweep all entries, then idle with the counter parked at 0
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == CLEAR) begin
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
                state_d = READY;
            end
        end else begin
            clr_cnt_d = '0;
            if (bus.init_req) begin
                state_d = CLEAR;
            end
        end
    end

    // Outputs and array strobes; init_req beats a same-cycle write
    always_comb begin
        busy_c    = 1'b0;
        clr_we_c  = 1'b0;
        wr_fire_c = 1'b0;
        if (state_q == CLEAR) begin
            busy_c   = 1'b1;
            clr_we_c = 1'b1;
        end else begin
            wr_fire_c = bus.wr_en && !bus.init_req && (bus.wr_addr != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (clr_we_c) begin
            mem_q[clr_cnt_q] <= '0;
        end else if (wr_fire_c) begin
            mem_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Asynchronous read ports; zero during the sweep and for entry 0
    always_comb begin
        logic [ADDR_W-1:0] ra;
        ra        = '0;
        rd_data_c = '0;
        for (int k = 0; k < int'(NUM_RD); k++) begin
            ra = bus.rd_addr[k*ADDR_W +: ADDR_W];
            if (!busy_c && (ra != '0)) begin
                rd_data_c[k*DATA_W +: DATA_W] = mem_q[ra];
`ifdef REGFILE_BYPASS_EN
                if (bus.wr_en && (bus.wr_addr == ra)) begin
                    rd_data_c[k*DATA_W +: DATA_W] = bus.wr_data;
                end
`endif
            end
        end
    end

    assign bus.rd_data = rd_data_c;
    assign bus.busy    = busy_c;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default 32x32x2 instance plus a 64-bit, 64-entry, 3-port instance.
module tb_regfile_mp;
    logic clk;
    logic rst_a;
    logic rst_b;
    int   errors = 0;
    int   checks = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ifa ();
    regfile_mp_if #(.DATA_W(64), .ADDR_W(6), .NUM_RD(3)) ifb ();

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) u_a (.clk(clk), .rst(rst_a), .bus(ifa));
    regfile_mp #(.DATA_W(64), .ADDR_W(6), .NUM_RD(3)) u_b (.clk(clk), .rst(rst_b), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_a(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra0, input logic [4:0] ra1, input logic init);
        ifa.wr_en    = we;
        ifa.wr_addr  = wa;
        ifa.wr_data  = wd;
        ifa.rd_addr  = {ra1, ra0};
        ifa.init_req = init;
    endtask

    // Counts rising edges until busy drops, bounded so a stuck sequencer still ends the run
    task automatic count_busy(input bit sel_b, output int n);
        n = 0;
        while ((sel_b ? ifb.busy : ifa.busy) && n < 300) begin
            @(posedge clk);
            n++;
            #1;
        end
    endtask

    task automatic read_all_zero_a(input string name);
        for (int i = 0; i < 32; i++) begin
            ifa.rd_addr = {5'(31 - i), 5'(i)};
            #1;
            check({name, " p0"}, {32'h0, ifa.rd_data[31:0]}, 64'h0);
            check({name, " p1"}, {32'h0, ifa.rd_data[63:32]}, 64'h0);
        end
    endtask

    initial begin
        int n;

        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd0,  5'd1,  32'h0,        32'h0};
        vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 5'd0,  32'h00001234, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
        vecs[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0};
        vecs[4] = '{1'b1, 5'd9,  32'h00000009, 5'd5,  5'd10, 32'hDEADBEEF, 32'h0};
        vecs[5] = '{1'b1, 5'd10, 32'hCAFEF00D, 5'd9,  5'd31, 32'h00000009, 32'h0};
        vecs[6] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd10, 5'd9,  32'hCAFEF00D, 32'h00000009};
        vecs[7] = '{1'b1, 5'd5,  32'h11111111, 5'd31, 5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[8] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd10, 32'h11111111, 32'hCAFEF00D};

        rst_a = 1'b1;
        rst_b = 1'b1;
        set_a(1'b0, 5'd0, 32'h0, 5'd5, 5'd6, 1'b0);
        ifb.wr_en = 1'b0; ifb.wr_addr = '0; ifb.wr_data = '0; ifb.rd_addr = '0; ifb.init_req = 1'b0;

        // Reset state and clear latency
        repeat (3) @(negedge clk);
        check("reset busy", {63'h0, ifa.busy}, 64'h1);
        check("reset rd", {32'h0, ifa.rd_data[31:0]} | {32'h0, ifa.rd_data[63:32]}, 64'h0);
        rst_a = 1'b0;
        count_busy(1'b0, n);
        check("reset clear edges", 64'(n), 64'd32);
        read_all_zero_a("post reset zero");

        // Table of writes and reads
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            set_a(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra0, vecs[i].ra1, 1'b0);
            @(negedge clk);
            check($sformatf("vec%0d p0", i), {32'h0, ifa.rd_data[31:0]},  {32'h0, vecs[i].e0});
            check($sformatf("vec%0d p1", i), {32'h0, ifa.rd_data[63:32]}, {32'h0, vecs[i].e1});
        end

        // Same-cycle write and read of reg 7
        @(posedge clk); #1;
        set_a(1'b1, 5'd7, 32'hA5A5A5A5, 5'd5, 5'd7, 1'b0);
        @(negedge clk);
        check("bypass p1 same cycle", {32'h0, ifa.rd_data[63:32]}, BYP ? 64'hA5A5A5A5 : 64'h0);
        check("bypass p0 unrelated", {32'h0, ifa.rd_data[31:0]}, 64'h11111111);
        @(posedge clk); #1;
        set_a(1'b0, 5'd0, 32'h0, 5'd5, 5'd7, 1'b0);
        @(negedge clk);
        check("bypass p1 next cycle", {32'h0, ifa.rd_data[63:32]}, 64'hA5A5A5A5);

        // Fill, then init_req with a colliding write
        for (int i = 1; i < 32; i++) begin
            @(posedge clk); #1;
            set_a(1'b1, 5'(i), 32'h100 + 32'(i), 5'd0, 5'd0, 1'b0);
        end
        @(posedge clk); #1;
        set_a(1'b0, 5'd0, 32'h0, 5'd3, 5'd31, 1'b0);
        @(negedge clk);
        check("fill reg3", {32'h0, ifa.rd_data[31:0]}, 64'h103);
        check("fill reg31", {32'h0, ifa.rd_data[63:32]}, 64'h11F);
        @(posedge clk); #1;
        set_a(1'b1, 5'd3, 32'h55, 5'd3, 5'd31, 1'b1);
        @(negedge clk);
        check("busy before init edge", {63'h0, ifa.busy}, 64'h0);
        @(posedge clk); #1;
        check("init busy rise", {63'h0, ifa.busy}, 64'h1);
        set_a(1'b1, 5'd3, 32'h00000BAD, 5'd3, 5'd4, 1'b0);
        #1;
        check("rd forced zero in clear", {ifa.rd_data[31:0], ifa.rd_data[63:32]}, 64'h0);
        count_busy(1'b0, n);
        set_a(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
        check("init clear edges", 64'(n), 64'd32);
        read_all_zero_a("post init zero");

        // Asynchronous reset in the middle of a sweep
        @(posedge clk); #1;
        set_a(1'b1, 5'd12, 32'h0000ABCD, 5'd0, 5'd0, 1'b0);
        @(posedge clk); #1;
        set_a(1'b0, 5'd0, 32'h0, 5'd12, 5'd20, 1'b1);
        @(negedge clk);
        check("reg12 before init", {32'h0, ifa.rd_data[31:0]}, 64'hABCD);
        @(posedge clk); #1;
        set_a(1'b1, 5'd20, 32'h0000DEAD, 5'd12, 5'd20, 1'b0);
        repeat (10) @(posedge clk);
        #2 rst_a = 1'b1;
        #1 check("mid-clear rst busy", {63'h0, ifa.busy}, 64'h1);
        #3 rst_a = 1'b0;
        count_busy(1'b0, n);
        set_a(1'b0, 5'd0, 32'h0, 5'd12, 5'd20, 1'b0);
        check("restart clear edges", 64'(n), 64'd32);
        #1;
        check("reg12 swept", {32'h0, ifa.rd_data[31:0]}, 64'h0);
        check("reg20 write ignored", {32'h0, ifa.rd_data[63:32]}, 64'h0);

        // Wide instance: 64 entries, three ports
        @(negedge clk);
        rst_b = 1'b0;
        count_busy(1'b1, n);
        check("wide clear edges", 64'(n), 64'd64);
        ifb.wr_en = 1'b1; ifb.wr_addr = 6'd63; ifb.wr_data = 64'hFFFF0000FFFF0000;
        ifb.rd_addr = {6'd0, 6'd1, 6'd62};
        @(negedge clk);
        check("wide p0 pre", ifb.rd_data[63:0], 64'h0);
        @(posedge clk); #1;
        ifb.wr_en = 1'b1; ifb.wr_addr = 6'd0; ifb.wr_data = 64'h1234;
        ifb.rd_addr = {6'd63, 6'd63, 6'd63};
        @(negedge clk);
        check("wide p0 reg63", ifb.rd_data[63:0],    64'hFFFF0000FFFF0000);
        check("wide p1 reg63", ifb.rd_data[127:64],  64'hFFFF0000FFFF0000);
        check("wide p2 reg63", ifb.rd_data[191:128], 64'hFFFF0000FFFF0000);
        @(posedge clk); #1;
        ifb.wr_en = 1'b0;
        ifb.rd_addr = {6'd0, 6'd63, 6'd0};
        #1;
        check("wide reg0 zero", ifb.rd_data[63:0], 64'h0);
        check("wide p1 hold", ifb.rd_data[127:64], 64'hFFFF0000FFFF0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
